// File: rtl/credit_switch_scheduler.sv
// credit_switch_scheduler: credit-aware separable switch allocator (input-first).
// Stage 1 picks one VC per input, stage 2 picks one input per output, both
// round-robin. Grants are registered; the registered grant doubles as the
// one-cycle re-grant mask that covers the upstream request-clear lag.
// Optional macro SCHED_CREDIT_CHECK_EN: enables per-output downstream credit
// counters, credit gating and the sticky credit_err flag. When undefined,
// every output has infinite credit.

// Round-robin picker: first asserted request at or after ptr, wrapping.
module credit_switch_rr #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);
  // Scan farthest offset first so the request nearest the pointer wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

module credit_switch_scheduler #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VC       = 4,
  parameter int CREDIT_DEPTH = NUM_VC,
  parameter int VC_BITS      = $clog2(NUM_VC),
  parameter int CNT_BITS     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_VC*NUM_PORTS-1:0][NUM_PORTS-1:0] vc_dst_port,
  input  logic                                    stall,
  input  logic [NUM_PORTS-2:0]                    dwnstr_router_increment,
  output logic [NUM_PORTS-1:0]                    grant_valid,
  output logic [NUM_PORTS-1:0][VC_BITS-1:0]       grant_vc,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     grant_out_port,
  output logic [NUM_PORTS-2:0][CNT_BITS-1:0]      credit_count,
  output logic                                    credit_err
);
  localparam int PB = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0][VC_BITS-1:0]   in_ptr;
  logic [NUM_PORTS-1:0][PB-1:0]        out_ptr;
  logic [NUM_PORTS-1:0]                has_credit;
  logic [NUM_PORTS-1:0][NUM_VC-1:0]    elig;
  logic [NUM_PORTS-1:0]                cand_valid;
  logic [NUM_PORTS-1:0][VC_BITS-1:0]   cand_vc;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] cand_port;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_req;   // [output][input]
  logic [NUM_PORTS-1:0]                out_win_valid;
  logic [NUM_PORTS-1:0][PB-1:0]        out_win;
  logic [NUM_PORTS-1:0]                grant_to;  // per output, stall applied
  logic [NUM_PORTS-1:0]                new_valid;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] new_port;

  // Eligible: target has credit (implies a request) and VC not granted last cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_VC; j++) begin
        elig[i][j] = (|(vc_dst_port[i*NUM_VC+j] & has_credit)) &&
                     !(grant_valid[i] && grant_vc[i] == VC_BITS'(j));
      end
    end
  end

  // Stage 1: one candidate VC per input.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    credit_switch_rr #(.N(NUM_VC), .PW(VC_BITS)) u_in_rr (
      .req(elig[i]), .ptr(in_ptr[i]),
      .gnt_valid(cand_valid[i]), .gnt_idx(cand_vc[i])
    );
    assign cand_port[i] = cand_valid[i] ? vc_dst_port[i*NUM_VC + int'(cand_vc[i])] : '0;
  end

  // Regroup candidates by the output they target.
  always_comb begin
    out_req = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        out_req[o][i] = cand_port[i][o];
  end

  // Stage 2: one input per output.
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    credit_switch_rr #(.N(NUM_PORTS), .PW(PB)) u_out_rr (
      .req(out_req[o]), .ptr(out_ptr[o]),
      .gnt_valid(out_win_valid[o]), .gnt_idx(out_win[o])
    );
  end

  // Final grant per input: stage-2 winners, all dropped under stall.
  always_comb begin
    grant_to  = out_win_valid & {NUM_PORTS{~stall}};
    new_valid = '0;
    new_port  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_to[o] && out_win[o] == PB'(i)) begin
          new_valid[i]   = 1'b1;
          new_port[i][o] = 1'b1;
        end
      end
    end
  end

  // Registered grants; these also serve as next cycle's re-grant mask.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_valid    <= '0;
      grant_vc       <= '0;
      grant_out_port <= '0;
    end else begin
      grant_valid    <= new_valid;
      grant_out_port <= new_port;
      for (int i = 0; i < NUM_PORTS; i++)
        grant_vc[i] <= new_valid[i] ? cand_vc[i] : '0;
    end
  end

  // Round-robin pointers advance past the winner; hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (new_valid[i]) in_ptr[i] <= VC_BITS'((int'(cand_vc[i]) + 1) % NUM_VC);
      for (int o = 0; o < NUM_PORTS; o++)
        if (grant_to[o]) out_ptr[o] <= PB'((int'(out_win[o]) + 1) % NUM_PORTS);
    end
  end

`ifdef SCHED_CREDIT_CHECK_EN
  // Non-local outputs need a free downstream slot; local eject never blocks.
  always_comb begin
    has_credit = '1;
    for (int o = 0; o < NUM_PORTS - 1; o++)
      has_credit[o] = (credit_count[o] != '0);
  end

  // Credit counters: grant consumes, return pulse restores, saturate + flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS - 1; o++)
        credit_count[o] <= CNT_BITS'(CREDIT_DEPTH);
      credit_err <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS - 1; o++) begin
        if (grant_to[o] && !dwnstr_router_increment[o]) begin
          credit_count[o] <= credit_count[o] - CNT_BITS'(1);
        end else if (!grant_to[o] && dwnstr_router_increment[o]) begin
          if (credit_count[o] == CNT_BITS'(CREDIT_DEPTH)) credit_err <= 1'b1;
          else credit_count[o] <= credit_count[o] + CNT_BITS'(1);
        end
      end
    end
  end
`else
  logic unused_inc;
  assign unused_inc = ^dwnstr_router_increment;
  assign has_credit = '1;
  assign credit_err = 1'b0;

  // Infinite credit: counters read as permanently full.
  always_comb begin
    credit_count = '0;
    for (int o = 0; o < NUM_PORTS - 1; o++)
      credit_count[o] = CNT_BITS'(CREDIT_DEPTH);
  end
`endif

endmodule

// File: tb/tb_credit_switch_scheduler.sv
// Bench for credit_switch_scheduler: directed scenarios plus randomized traffic
// against a behavioural allocator model. Honors SCHED_CREDIT_CHECK_EN.
module tb_credit_switch_scheduler;
  localparam int NP = 5, NV = 4, DEPTH = 4, VB = 2, CB = 3;
`ifdef SCHED_CREDIT_CHECK_EN
  localparam bit CRED = 1'b1;
`else
  localparam bit CRED = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic [NP-2:0] inc = '0;
  logic [NV*NP-1:0][NP-1:0] vc_dst;
  logic [NP-1:0]          grant_valid;
  logic [NP-1:0][VB-1:0]  grant_vc;
  logic [NP-1:0][NP-1:0]  grant_out_port;
  logic [NP-2:0][CB-1:0]  credit_count;
  logic                   credit_err;

  int req_port [NP][NV];   // -1: no request, else target output
  int checks = 0, fails = 0;

  // Model state
  bit m_gv [NP]; int m_gvc [NP]; int m_gp [NP];
  int m_inptr [NP]; int m_outptr [NP]; int m_cred [NP-1]; bit m_err;
  logic [NP-1:0] e_gv; logic [NP-1:0][VB-1:0] e_gvc; logic [NP-1:0][NP-1:0] e_gport;
  logic [NP-2:0][CB-1:0] e_cred; logic e_err;

  credit_switch_scheduler #(.NUM_PORTS(NP), .NUM_VC(NV)) dut (
    .clk(clk), .reset(rst_n), .vc_dst_port(vc_dst), .stall(stall),
    .dwnstr_router_increment(inc), .grant_valid(grant_valid), .grant_vc(grant_vc),
    .grant_out_port(grant_out_port), .credit_count(credit_count), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    vc_dst = '0;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < NV; j++)
        if (req_port[i][j] >= 0) vc_dst[i*NV+j][req_port[i][j]] = 1'b1;
  end

  // Behavioural allocator: one edge worth of scheduling from the spec rules.
  function automatic void model_step();
    int cv [NP]; int cp [NP]; int win [NP]; int j, p, i;
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        m_gv[k] = 0; m_gvc[k] = 0; m_gp[k] = -1; m_inptr[k] = 0; m_outptr[k] = 0;
      end
      for (int o = 0; o < NP-1; o++) m_cred[o] = DEPTH;
      m_err = 0;
    end else begin
      for (int a = 0; a < NP; a++) begin
        cv[a] = -1; cp[a] = -1;
        for (int k = 0; k < NV; k++) begin
          j = (m_inptr[a] + k) % NV; p = req_port[a][j];
          if (cv[a] < 0 && p >= 0 && (p == NP-1 || !CRED || m_cred[p] > 0) &&
              !(m_gv[a] && m_gvc[a] == j)) begin
            cv[a] = j; cp[a] = p;
          end
        end
      end
      for (int o = 0; o < NP; o++) begin
        win[o] = -1;
        if (!stall)
          for (int k = 0; k < NP; k++) begin
            i = (m_outptr[o] + k) % NP;
            if (win[o] < 0 && cv[i] >= 0 && cp[i] == o) win[o] = i;
          end
      end
      for (int a = 0; a < NP; a++) begin m_gv[a] = 0; m_gvc[a] = 0; m_gp[a] = -1; end
      for (int o = 0; o < NP; o++)
        if (win[o] >= 0) begin
          i = win[o];
          m_gv[i] = 1; m_gvc[i] = cv[i]; m_gp[i] = o;
          m_inptr[i] = (cv[i] + 1) % NV; m_outptr[o] = (i + 1) % NP;
        end
      if (CRED)
        for (int o = 0; o < NP-1; o++) begin
          if (win[o] >= 0 && !inc[o]) m_cred[o]--;
          else if (win[o] < 0 && inc[o]) begin
            if (m_cred[o] == DEPTH) m_err = 1; else m_cred[o]++;
          end
        end
    end
    for (int a = 0; a < NP; a++) begin
      e_gv[a] = m_gv[a]; e_gvc[a] = VB'(m_gvc[a]); e_gport[a] = '0;
      if (m_gp[a] >= 0) e_gport[a][m_gp[a]] = 1'b1;
    end
    for (int o = 0; o < NP-1; o++) e_cred[o] = CB'(m_cred[o]);
    e_err = m_err;
  endfunction

  task automatic tick();
    @(posedge clk); model_step(); @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NP; i++) for (int j = 0; j < NV; j++) req_port[i][j] = -1;
  endtask

  task automatic pulse_reset();
    clear_reqs(); stall = 0; inc = '0; rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < NV; j++) req_port[i][j] = int'($urandom_range(0, 5)) - 1;
      inc = NP'($urandom) ; tick();
      checks++;
      if (grant_valid !== '0 || grant_vc !== '0 || grant_out_port !== '0) begin
        fails++; $display("FAIL reset_grants: got v=%b vc=%h port=%h, expected all 0", grant_valid, grant_vc, grant_out_port);
      end
      checks++;
      if (credit_count !== {(NP-1){CB'(DEPTH)}} || credit_err !== 1'b0) begin
        fails++; $display("FAIL reset_credits: got cnt=%h err=%b, expected cnt=%h err=0", credit_count, credit_err, {(NP-1){CB'(DEPTH)}});
      end
    end
    clear_reqs(); inc = '0; rst_n = 1;
  endtask

  task automatic test_output_contention();
    int seq[$];
    pulse_reset();
    req_port[0][0] = 3; req_port[1][0] = 3; req_port[2][0] = 3;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({grant_valid, grant_vc, grant_out_port, credit_count} !== {e_gv, e_gvc, e_gport, e_cred}) begin
        fails++; $display("FAIL contention_model c=%0d: got v=%b vc=%h port=%h cnt=%h, expected v=%b vc=%h port=%h cnt=%h",
          c, grant_valid, grant_vc, grant_out_port, credit_count, e_gv, e_gvc, e_gport, e_cred);
      end
      for (int i = 0; i < NP; i++) if (grant_valid[i] && grant_out_port[i][3]) seq.push_back(i);
    end
    checks++;
    if (seq.size() < 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 0) begin
      fails++; $display("FAIL contention_order: got %p, expected 0,1,2,0 first", seq);
    end
    checks++;
    if (seq.size() != (CRED ? 4 : 8) || credit_count[3] !== CB'(CRED ? 0 : DEPTH)) begin
      fails++; $display("FAIL contention_credit: got %0d grants cnt3=%0d, expected %0d grants cnt3=%0d",
        seq.size(), credit_count[3], CRED ? 4 : 8, CRED ? 0 : DEPTH);
    end
  endtask

  task automatic test_vc_fairness();
    int seq[$]; int pend = -1;
    pulse_reset();
    for (int j = 0; j < NV; j++) req_port[1][j] = 4;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if ({grant_valid, grant_vc, grant_out_port} !== {e_gv, e_gvc, e_gport}) begin
        fails++; $display("FAIL vc_fair_model c=%0d: got v=%b vc=%h port=%h, expected v=%b vc=%h port=%h",
          c, grant_valid, grant_vc, grant_out_port, e_gv, e_gvc, e_gport);
      end
      if (pend >= 0) req_port[1][pend] = -1;
      pend = -1;
      if (grant_valid[1]) begin seq.push_back(int'(grant_vc[1])); pend = int'(grant_vc[1]); end
    end
    checks++;
    if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3) begin
      fails++; $display("FAIL vc_fair_order: got %p, expected 0,1,2,3", seq);
    end
    checks++;
    if (credit_count !== {(NP-1){CB'(DEPTH)}}) begin
      fails++; $display("FAIL vc_fair_credits: got %h, expected all %0d", credit_count, DEPTH);
    end
  endtask

  task automatic test_credit_boundaries();
    pulse_reset();
    for (int i = 0; i < 4; i++) req_port[i][0] = 0;
    for (int c = 0; c < 4; c++) tick();
    clear_reqs();
    // empty counter + return + request in one cycle: grant waits a cycle
    req_port[0][1] = 0; inc = 4'b0001; tick();
    checks++;
    if (grant_valid[0] !== !CRED || credit_count[0] !== CB'(CRED ? 1 : DEPTH)) begin
      fails++; $display("FAIL cred_zero_inc: got v0=%b cnt0=%0d, expected v0=%b cnt0=%0d", grant_valid[0], credit_count[0], !CRED, CRED ? 1 : DEPTH);
    end
    inc = '0; tick();
    checks++;
    if (grant_valid[0] !== CRED || credit_count[0] !== CB'(CRED ? 0 : DEPTH) || {grant_vc, credit_count} !== {e_gvc, e_cred}) begin
      fails++; $display("FAIL cred_zero_next: got v0=%b vc=%h cnt=%h, expected v0=%b vc=%h cnt=%h", grant_valid[0], grant_vc, credit_count, CRED, e_gvc, e_cred);
    end
    clear_reqs(); inc = 4'b0001; tick(); tick();
    inc = 4'b0001; req_port[2][0] = 0; tick();
    checks++;
    if (grant_valid[2] !== 1'b1 || credit_count[0] !== CB'(CRED ? 2 : DEPTH)) begin
      fails++; $display("FAIL cred_grant_inc: got v2=%b cnt0=%0d, expected v2=1 cnt0=%0d", grant_valid[2], credit_count[0], CRED ? 2 : DEPTH);
    end
    clear_reqs(); tick(); tick(); tick();
    checks++;
    if (credit_count[0] !== CB'(DEPTH) || credit_err !== CRED) begin
      fails++; $display("FAIL cred_overflow: got cnt0=%0d err=%b, expected cnt0=%0d err=%b", credit_count[0], credit_err, DEPTH, CRED);
    end
    inc = '0; tick(); tick();
    checks++;
    if (credit_err !== CRED || credit_err !== e_err) begin
      fails++; $display("FAIL cred_err_sticky: got err=%b, expected err=%b", credit_err, CRED);
    end
    pulse_reset();
    checks++;
    if (credit_err !== 1'b0) begin
      fails++; $display("FAIL cred_err_reset: got err=%b, expected 0", credit_err);
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    req_port[0][0] = 3; req_port[1][0] = 3; req_port[2][0] = 3;
    tick(); tick();
    checks++;
    if (credit_count[3] !== CB'(CRED ? 2 : DEPTH)) begin
      fails++; $display("FAIL stall_pre_cnt: got %0d, expected %0d", credit_count[3], CRED ? 2 : DEPTH);
    end
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      inc = (c >= 1) ? 4'b1000 : 4'b0000; tick();
      checks++;
      if (grant_valid !== '0 || grant_out_port !== '0) begin
        fails++; $display("FAIL stall_grants c=%0d: got v=%b port=%h, expected 0", c, grant_valid, grant_out_port);
      end
    end
    stall = 0; inc = '0;
    checks++;
    if (credit_count[3] !== CB'(DEPTH)) begin
      fails++; $display("FAIL stall_inc: got %0d, expected %0d", credit_count[3], DEPTH);
    end
    tick();
    checks++;
    if (grant_valid !== 5'b00100 || grant_out_port[2] !== 5'b01000 || credit_count[3] !== CB'(CRED ? 3 : DEPTH)) begin
      fails++; $display("FAIL stall_resume: got v=%b port2=%b cnt3=%0d, expected v=00100 port2=01000 cnt3=%0d",
        grant_valid, grant_out_port[2], credit_count[3], CRED ? 3 : DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    pulse_reset();
    for (int i = 0; i < 4; i++) req_port[i][0] = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < NP; i++) if (grant_valid[i] && grant_out_port[i][0]) n++;
    end
    checks++;
    if (n != (CRED ? 4 : 6) || credit_count[0] !== CB'(CRED ? 0 : DEPTH)) begin
      fails++; $display("FAIL back_to_back: got %0d grants cnt0=%0d, expected %0d grants cnt0=%0d", n, credit_count[0], CRED ? 4 : 6, CRED ? 0 : DEPTH);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++)
        for (int j = 0; j < NV; j++)
          if ($urandom_range(0, 9) < 3) req_port[i][j] = int'($urandom_range(0, 6)) - 2;
      for (int i = 0; i < NP; i++) for (int j = 0; j < NV; j++) if (req_port[i][j] < -1) req_port[i][j] = -1;
      stall = ($urandom_range(0, 9) == 0);
      for (int o = 0; o < NP-1; o++) inc[o] = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      checks++;
      if ({grant_valid, grant_vc, grant_out_port} !== {e_gv, e_gvc, e_gport}) begin
        fails++; $display("FAIL random_grants c=%0d: got v=%b vc=%h port=%h, expected v=%b vc=%h port=%h",
          c, grant_valid, grant_vc, grant_out_port, e_gv, e_gvc, e_gport);
      end
      checks++;
      if ({credit_count, credit_err} !== {e_cred, e_err}) begin
        fails++; $display("FAIL random_credits c=%0d: got cnt=%h err=%b, expected cnt=%h err=%b", c, credit_count, credit_err, e_cred, e_err);
      end
    end
    rst_n = 1; stall = 0; inc = '0;
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_output_contention();
    test_vc_fairness();
    test_credit_boundaries();
    test_stall();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
